// File: rtl/sci_slave.sv
// sci_slave: peripheral-side endpoint of the Scalable Configuration Interface.
// Deserialises a WNR/address/write-data frame from SCI_CSN/SCI_REQ into a local
// register request. Once the local access finishes, it returns either a write
// completion or serial read data on SCI_ACK/SCI_RESP.
// Optional macro SCI_SLAVE_TRISTATE_EN: SCI_ACK/SCI_RESP become tri-state, and
// float whenever the registered chip select is high or the slave is idle.
module sci_slave #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  SCI_CSN,
    input  logic                  SCI_REQ,
    output logic                  SCI_RESP,
    output logic                  SCI_ACK,
    output logic                  REG_REQ,
    output logic                  REG_WNR,
    output logic [ADDR_WIDTH-1:0] REG_ADDR,
    output logic [DATA_WIDTH-1:0] REG_WDATA,
    input  logic [DATA_WIDTH-1:0] REG_RDATA,
    input  logic                  REG_ACK
);

    localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WDATA,
        S_ACCESS,
        S_WDONE,
        S_RDATA,
        S_RWAIT
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    ack_q, ack_d;
    logic                    req_q, req_d;
    logic                    wnr_q, wnr_d;
    logic                    abort_q, abort_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    // Address is staged here so an aborted frame leaves REG_ADDR untouched.
    logic [ADDR_WIDTH-1:0]   ash_q, ash_d;
    // Write data staging; the final bit is appended straight from SCI_REQ.
    logic [DATA_WIDTH-2:0]   wsh_q, wsh_d;
    // Read shift register; its MSB is the bit currently on SCI_RESP.
    logic [DATA_WIDTH-1:0]   rsh_q, rsh_d;

    // State register
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode from the sampled frame lines and the local handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!SCI_CSN) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (SCI_CSN)                 state_d = S_IDLE;
                else if (cnt_q == ADDR_LAST) state_d = wnr_q ? S_WDATA : S_ACCESS;
            end
            S_WDATA: begin
                if (SCI_CSN)                 state_d = S_IDLE;
                else if (cnt_q == DATA_LAST) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                // The local access always runs to completion; the master is
                // only answered if it kept chip select low throughout.
                if (REG_ACK) begin
                    if (abort_q || SCI_CSN) state_d = S_IDLE;
                    else if (wnr_q)         state_d = S_WDONE;
                    else                    state_d = S_RDATA;
                end
            end
            S_WDONE: begin
                if (SCI_CSN) state_d = S_IDLE;
            end
            S_RDATA: begin
                if (SCI_CSN)                 state_d = S_IDLE;
                else if (cnt_q == DATA_LAST) state_d = S_RWAIT;
            end
            S_RWAIT: begin
                if (SCI_CSN) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, shift registers and bit counter
    always_comb begin
        ack_d   = ack_q;
        req_d   = req_q;
        wnr_d   = wnr_q;
        abort_d = abort_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ash_d   = ash_q;
        wsh_d   = wsh_q;
        rsh_d   = rsh_q;
        // The counter restarts at every state entry.
        cnt_d   = (state_d != state_q) ? '0 : cnt_q;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (!SCI_CSN) wnr_d = SCI_REQ;
            end
            S_ADDR: begin
                ash_d = ADDR_WIDTH'({ash_q, SCI_REQ});
                if (state_d == S_ADDR) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (state_d == S_ACCESS) begin
                    req_d  = 1'b1;
                    addr_d = ADDR_WIDTH'({ash_q, SCI_REQ});
                end
            end
            S_WDATA: begin
                wsh_d = (DATA_WIDTH-1)'({wsh_q, SCI_REQ});
                if (state_d == S_WDATA) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (state_d == S_ACCESS) begin
                    req_d   = 1'b1;
                    addr_d  = ash_q;
                    wdata_d = {wsh_q, SCI_REQ};
                end
            end
            S_ACCESS: begin
                if (SCI_CSN) abort_d = 1'b1;
                if (REG_ACK) begin
                    req_d = 1'b0;
                    if (state_d == S_WDONE) begin
                        ack_d = 1'b1;
                    end else if (state_d == S_RDATA) begin
                        ack_d = 1'b1;
                        rsh_d = REG_RDATA;
                    end
                end
            end
            S_WDONE: begin
                if (state_d == S_IDLE) ack_d = 1'b0;
            end
            S_RDATA: begin
                if (state_d == S_RDATA) begin
                    cnt_d = cnt_q + CW'(1);
                    rsh_d = {rsh_q[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    ack_d = 1'b0;
                    rsh_d = '0;
                end
            end
            default: begin
            end
        endcase
    end

    // Output, datapath and counter registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            req_q   <= 1'b0;
            wnr_q   <= 1'b0;
            abort_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ash_q   <= '0;
            wsh_q   <= '0;
            rsh_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            req_q   <= req_d;
            wnr_q   <= wnr_d;
            abort_q <= abort_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ash_q   <= ash_d;
            wsh_q   <= wsh_d;
            rsh_q   <= rsh_d;
        end
    end

    assign REG_REQ   = req_q;
    assign REG_WNR   = wnr_q;
    assign REG_ADDR  = addr_q;
    assign REG_WDATA = wdata_q;

`ifdef SCI_SLAVE_TRISTATE_EN
    logic csn_q;

    // Registered chip select decides when this slave may drive the shared lines
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            csn_q <= 1'b1;
        end else begin
            csn_q <= SCI_CSN;
        end
    end

    assign SCI_ACK  = (csn_q || (state_q == S_IDLE)) ? 1'bz : ack_q;
    assign SCI_RESP = (csn_q || (state_q == S_IDLE)) ? 1'bz : rsh_q[DATA_WIDTH-1];
`else
    assign SCI_ACK  = ack_q;
    assign SCI_RESP = rsh_q[DATA_WIDTH-1];
`endif

endmodule

// File: tb/tb_sci_slave.sv
// Self-checking bench for sci_slave: directed frames from the test plan plus
// randomized write/read/abort frames, checked against a register-file model.
module tb_sci_slave;

    localparam int AW = 4;
    localparam int DW = 8;

`ifdef SCI_SLAVE_TRISTATE_EN
    localparam logic IDLE_V = 1'bz;
`else
    localparam logic IDLE_V = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          SCI_CSN;
    logic          SCI_REQ;
    logic          SCI_RESP;
    logic          SCI_ACK;
    logic          REG_REQ;
    logic          REG_WNR;
    logic [AW-1:0] REG_ADDR;
    logic [DW-1:0] REG_WDATA;
    logic [DW-1:0] REG_RDATA;
    logic          REG_ACK;

    int n_checks = 0;
    int n_err    = 0;
    int ack_delay = 0;

    // Peripheral register file behind the slave, and the bench's expectation of it
    logic [DW-1:0] periph_mem [2**AW];
    logic [DW-1:0] model_mem  [2**AW];

    sci_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .SCI_CSN   (SCI_CSN),
        .SCI_REQ   (SCI_REQ),
        .SCI_RESP  (SCI_RESP),
        .SCI_ACK   (SCI_ACK),
        .REG_REQ   (REG_REQ),
        .REG_WNR   (REG_WNR),
        .REG_ADDR  (REG_ADDR),
        .REG_WDATA (REG_WDATA),
        .REG_RDATA (REG_RDATA),
        .REG_ACK   (REG_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Local peripheral: acknowledges a request after ack_delay waiting cycles
    initial begin
        int wait_n;
        wait_n    = 0;
        REG_ACK   = 1'b0;
        REG_RDATA = '0;
        forever begin
            @(negedge CLK);
            if (REG_REQ === 1'b1 && REG_ACK === 1'b0) begin
                if (wait_n >= ack_delay) begin
                    REG_ACK   = 1'b1;
                    REG_RDATA = periph_mem[REG_ADDR];
                    if (REG_WNR) periph_mem[REG_ADDR] = REG_WDATA;
                    wait_n = 0;
                end else begin
                    wait_n++;
                end
            end else begin
                REG_ACK = 1'b0;
                wait_n  = 0;
            end
        end
    end

    // Full frame; entered at a negedge with CSN high, leaves after a 1-cycle CSN-high gap
    task automatic do_frame(input logic wnr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int dly, input int hold_n, input int rst_after);
        int held;
        ack_delay = dly;
        SCI_CSN = 1'b0;
        SCI_REQ = wnr;
        @(negedge CLK);
        for (int i = AW-1; i >= 0; i--) begin
            SCI_REQ = a[i];
            check_eq("req_early", REG_REQ, 1'b0);
            @(negedge CLK);
        end
        if (wnr) begin
            for (int i = DW-1; i >= 0; i--) begin
                SCI_REQ = d[i];
                check_eq("req_early", REG_REQ, 1'b0);
                @(negedge CLK);
            end
        end
        SCI_REQ = 1'b0;
        held = 0;
        while (REG_REQ === 1'b1 && held < 40) begin
            check_eq("reg_wnr", REG_WNR, wnr);
            check_eq("reg_addr", REG_ADDR, a);
            if (wnr) check_eq("reg_wdata", REG_WDATA, d);
            check_eq("ack_early", SCI_ACK, 1'b0);
            held++;
            @(negedge CLK);
        end
        check_eq("req_cycles", held, dly + 1);
        if (wnr) begin
            model_mem[a] = d;
            check_eq("wr_ack", SCI_ACK, 1'b1);
            repeat (hold_n) begin
                @(negedge CLK);
                check_eq("wr_ack_hold", SCI_ACK, 1'b1);
            end
            SCI_CSN = 1'b1;
            @(negedge CLK);
            check_eq("wr_gap_ack", SCI_ACK, IDLE_V);
        end else begin
            for (int i = DW-1; i >= 0; i--) begin
                if (rst_after == DW-1-i) begin
                    RSTN = 1'b0;
                    #1;
                    check_eq("rst_ack", SCI_ACK, IDLE_V);
                    check_eq("rst_resp", SCI_RESP, IDLE_V);
                    check_eq("rst_req", REG_REQ, 1'b0);
                    check_eq("rst_addr", REG_ADDR, '0);
                    @(negedge CLK);
                    RSTN    = 1'b1;
                    SCI_CSN = 1'b1;
                    @(negedge CLK);
                    return;
                end
                check_eq("rd_ack", SCI_ACK, 1'b1);
                check_eq("rd_bit", SCI_RESP, model_mem[a][i]);
                @(negedge CLK);
            end
            check_eq("rd_ack_end", SCI_ACK, 1'b0);
            check_eq("rd_resp_end", SCI_RESP, 1'b0);
            SCI_CSN = 1'b1;
            @(negedge CLK);
            check_eq("rd_gap_ack", SCI_ACK, IDLE_V);
            check_eq("rd_gap_resp", SCI_RESP, IDLE_V);
        end
    endtask

    // Frame cut short after nbits address bits; no local access may follow
    task automatic abort_frame(input logic wnr, input logic [AW-1:0] a, input int nbits);
        SCI_CSN = 1'b0;
        SCI_REQ = wnr;
        @(negedge CLK);
        for (int i = 0; i < nbits; i++) begin
            SCI_REQ = a[AW-1-i];
            @(negedge CLK);
        end
        SCI_CSN = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check_eq("abort_req", REG_REQ, 1'b0);
            check_eq("abort_ack", SCI_ACK, IDLE_V);
        end
    endtask

    initial begin
        logic          r_wnr;
        logic [AW-1:0] r_a;
        logic [DW-1:0] r_d;
        int            r_dly;
        int            r_hold;
        RSTN    = 1'b0;
        SCI_CSN = 1'b1;
        SCI_REQ = 1'b0;
        for (int i = 0; i < 2**AW; i++) begin
            periph_mem[i] = DW'($urandom);
            model_mem[i]  = periph_mem[i];
        end
        periph_mem[3] = 8'hC3;
        model_mem[3]  = 8'hC3;
        repeat (3) @(negedge CLK);
        check_eq("reset_ack", SCI_ACK, IDLE_V);
        check_eq("reset_resp", SCI_RESP, IDLE_V);
        check_eq("reset_req", REG_REQ, 1'b0);
        check_eq("reset_wnr", REG_WNR, 1'b0);
        check_eq("reset_addr", REG_ADDR, '0);
        check_eq("reset_wdata", REG_WDATA, '0);
        RSTN = 1'b1;
        @(negedge CLK);

        do_frame(1'b1, 4'hA, 8'h5C, 0, 2, -1);
        do_frame(1'b0, 4'h3, 8'h00, 0, 0, -1);
        do_frame(1'b1, 4'h6, 8'h99, 6, 1, -1);
        do_frame(1'b0, 4'h6, 8'h00, 6, 0, -1);
        abort_frame(1'b1, 4'h5, 2);
        do_frame(1'b1, 4'h5, 8'h3E, 1, 0, -1);
        do_frame(1'b0, 4'h5, 8'h00, 0, 0, -1);
        do_frame(1'b0, 4'hA, 8'h00, 2, 0, 3);
        do_frame(1'b0, 4'hA, 8'h00, 0, 0, -1);
        do_frame(1'b0, 4'h3, 8'h00, 1, 0, -1);
        do_frame(1'b1, 4'h3, 8'h81, 0, 0, -1);
        do_frame(1'b0, 4'h3, 8'h00, 0, 0, -1);

        for (int n = 0; n < 40; n++) begin
            r_wnr  = 1'($urandom);
            r_a    = AW'($urandom);
            r_d    = DW'($urandom);
            r_dly  = int'($urandom_range(0, 6));
            r_hold = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)
                abort_frame(r_wnr, r_a, int'($urandom_range(0, AW-1)));
            else
                do_frame(r_wnr, r_a, r_d, r_dly, r_hold, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
